// File: rtl/matriz_varredura_pkg.sv
// ---------------------------------------------------------------------------
// matriz_pkg: shared constants, scan states and row-code helper (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package matriz_pkg;

    localparam int          N_ROWS  = 7;
    localparam int          N_COLS  = 5;
    localparam logic [2:0]  SEL_OFF = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Row Lk is lit by decoder code 7-k; code 7 therefore means no row.
    function automatic logic [2:0] row_to_sel(input logic [2:0] k);
        return 3'd7 - k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matriz_varredura_checa_dois_de_cinco.sv
// ---------------------------------------------------------------------------
// checa_dois_de_cinco: flags whether a 5-bit word has exactly two ones (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module checa_dois_de_cinco (
    input  logic [4:0] data,
    output logic       ok
);

    logic [2:0] ones;

    assign ones = {2'b00, data[0]} + {2'b00, data[1]} + {2'b00, data[2]}
                + {2'b00, data[3]} + {2'b00, data[4]};
    assign ok   = (ones == 3'd2);

endmodule

`default_nettype wire

// File: rtl/matriz_varredura.sv
// ---------------------------------------------------------------------------
// matriz_varredura: 7x5 LED matrix row-scan controller, double-buffered (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module matriz_varredura
    import matriz_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_row,
    input  logic [N_COLS-1:0] wr_data,
    input  logic              commit,
    output logic [2:0]        sel,
    output logic [N_COLS-1:0] col,
    output logic              frame_tick,
    output logic              commit_pend,
    output logic              code_err
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);

    state_t                          state, state_n;
    logic [2:0]                      row, row_n;
    logic [TW-1:0]                   timer, timer_n;
    logic [2:0]                      sel_n;
    logic [N_COLS-1:0]               col_n;
    logic                            tick_n;
    logic                            boundary;

    logic [N_ROWS-1:0][N_COLS-1:0]   front;
    logic [N_ROWS-1:0][N_COLS-1:0]   back;
    logic                            data_ok;
    logic                            wr_fire;
    logic                            commit_ok;
    logic                            swap;

    checa_dois_de_cinco u_checa (
        .data (wr_data),
        .ok   (data_ok)
    );

    // ------------------------------------------------------------------
    // Scan sequencer: sel/col are registered alongside the state so a row
    // change never shows an intermediate code on the decoder.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= 3'd1;
            timer      <= '0;
            sel        <= SEL_OFF;
            col        <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            timer      <= timer_n;
            sel        <= sel_n;
            col        <= col_n;
            frame_tick <= tick_n;
        end
    end

    always_comb begin
        state_n  = state;
        row_n    = row;
        timer_n  = timer;
        sel_n    = sel;
        col_n    = col;
        tick_n   = 1'b0;
        boundary = 1'b0;
        if (!en) begin
            state_n = IDLE;
            row_n   = 3'd1;
            timer_n = '0;
            sel_n   = SEL_OFF;
            col_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    row_n   = 3'd1;
                    timer_n = '0;
                    sel_n   = SEL_OFF;
                    col_n   = '0;
                end
                BLANK: begin
                    if (timer == BLANK_LAST) begin
                        state_n = DRIVE;
                        timer_n = '0;
                        sel_n   = row_to_sel(row);
                        col_n   = front[row - 3'd1];
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                DRIVE: begin
                    if (timer == DWELL_LAST) begin
                        state_n = BLANK;
                        timer_n = '0;
                        sel_n   = SEL_OFF;
                        col_n   = '0;
                        if (row == 3'(N_ROWS)) begin
                            row_n    = 3'd1;
                            tick_n   = 1'b1;
                            boundary = 1'b1;
                        end else begin
                            row_n = row + 3'd1;
                        end
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    row_n   = 3'd1;
                    timer_n = '0;
                    sel_n   = SEL_OFF;
                    col_n   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame store and write/commit handshake. The back buffer is frozen
    // while a commit is pending, so a write can never race the swap.
    // ------------------------------------------------------------------
    assign wr_ready  = !commit_pend;
    assign wr_fire   = wr_valid && wr_ready;
    assign commit_ok = commit && !commit_pend;
    assign swap      = commit_pend && (boundary || (state == IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front       <= '0;
            back        <= '0;
            commit_pend <= 1'b0;
            code_err    <= 1'b0;
        end else begin
            if (swap) begin
                front       <= back;
                commit_pend <= 1'b0;
            end else if (commit_ok) begin
                commit_pend <= 1'b1;
            end

            if (wr_fire && (wr_row != 3'd0))
                back[wr_row - 3'd1] <= wr_data;

            // A bad write in the same cycle as a commit belongs to the new
            // snapshot, so its error survives the clear.
            if (commit_ok)
                code_err <= 1'b0;
            if (wr_fire && ((wr_row == 3'd0) || !data_ok))
                code_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matriz_varredura.sv
// ---------------------------------------------------------------------------
// tb_matriz_varredura: directed + random checks against a timeline model (Rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_matriz_varredura;

    localparam int DW     = 4;
    localparam int BL     = 1;
    localparam int SLOT   = BL + DW;
    localparam int PERIOD = 7 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [4:0] wr_data;
    logic       commit;
    logic [2:0] sel;
    logic [4:0] col;
    logic       frame_tick;
    logic       commit_pend;
    logic       code_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: scan position is a cycle count since enable.
    int         m_n;
    bit         m_active;
    logic [4:0] m_front [1:7];
    logic [4:0] m_back  [1:7];
    bit         m_pend;
    bit         m_err;

    matriz_varredura #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .commit      (commit),
        .sel         (sel),
        .col         (col),
        .frame_tick  (frame_tick),
        .commit_pend (commit_pend),
        .code_err    (code_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_active = 0;
        m_pend = 0;
        m_err = 0;
        for (int r = 1; r <= 7; r++) begin
            m_front[r] = '0;
            m_back[r]  = '0;
        end
    endtask

    task automatic model_edge();
        bit fire, accept, swap;
        fire   = wr_valid && !m_pend;
        accept = commit && !m_pend;
        swap   = m_pend && (!m_active || (en && ((m_n + 1) % PERIOD == 0)));
        if (!en) m_active = 0;
        else if (!m_active) begin m_active = 1; m_n = 0; end
        else m_n++;
        if (swap) begin
            for (int r = 1; r <= 7; r++) m_front[r] = m_back[r];
            m_pend = 0;
        end else if (accept) begin
            m_pend = 1;
        end
        if (fire && wr_row != 0) m_back[wr_row] = wr_data;
        if (accept) m_err = 0;
        if (fire && (wr_row == 0 || $countones(wr_data) != 2)) m_err = 1;
    endtask

    task automatic check_all();
        int ph, r;
        logic [2:0] es;
        logic [4:0] ec;
        logic       et;
        es = 3'b111; ec = '0; et = 1'b0;
        if (m_active) begin
            ph = m_n % PERIOD;
            r  = ph / SLOT + 1;
            if (ph % SLOT >= BL) begin
                es = 3'(7 - r);
                ec = m_front[r];
            end
            et = (m_n > 0) && (ph == 0);
        end
        chk("sel", 8'(sel), 8'(es));
        chk("col", 8'(col), 8'(ec));
        chk("frame_tick", 8'(frame_tick), 8'(et));
        chk("wr_ready", 8'(wr_ready), 8'(!m_pend));
        chk("commit_pend", 8'(commit_pend), 8'(m_pend));
        chk("code_err", 8'(code_err), 8'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_row(input logic [2:0] r, input logic [4:0] d);
        wr_valid = 1'b1; wr_row = r; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        for (int i = 0; i < 3 * PERIOD && frame_tick !== 1'b1; i++) step();
        chk(tag, 8'(frame_tick), 8'd1);
    endtask

    initial begin
        logic [4:0] pat [1:7];
        logic [4:0] d;
        int a, b;
        pat[1] = 5'b11000; pat[2] = 5'b10100; pat[3] = 5'b10010; pat[4] = 5'b10001;
        pat[5] = 5'b01100; pat[6] = 5'b01010; pat[7] = 5'b00110;

        rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_row = 3'd1; wr_data = '0; commit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Blank frame: scan sequence and frame tick spacing
        en = 1'b1;
        run(2 * PERIOD + 5);

        // Load a full 2-of-5 pattern and publish it
        for (int r = 1; r <= 7; r++) write_row(3'(r), pat[r]);
        pulse_commit();
        chk("pend_after_commit", 8'(commit_pend), 8'd1);
        chk("ready_after_commit", 8'(wr_ready), 8'd0);
        wait_tick("tick_for_swap");
        chk("pend_after_swap", 8'(commit_pend), 8'd0);
        run(PERIOD + 3);
        chk("err_clean_pattern", 8'(code_err), 8'd0);

        // Non code word is flagged but still stored and shown
        write_row(3'd3, 5'b11100);
        chk("err_bad_word", 8'(code_err), 8'd1);
        pulse_commit();
        chk("err_cleared_by_commit", 8'(code_err), 8'd0);
        wait_tick("tick_bad_word");
        run(PERIOD);

        // Row 0 completes the handshake, changes nothing, sets the error
        write_row(3'd0, 5'b00011);
        chk("err_row_zero", 8'(code_err), 8'd1);
        pulse_commit();
        wait_tick("tick_row_zero");
        run(PERIOD);

        // Drop enable while row 4 is being driven
        for (int i = 0; i < 2 * PERIOD && sel !== 3'b011; i++) step();
        chk("reach_row4", 8'(sel), 8'h03);
        en = 1'b0;
        step();
        chk("en_off_sel", 8'(sel), 8'h07);
        chk("en_off_col", 8'(col), 8'h00);
        en = 1'b1;
        step();
        chk("reen_blank", 8'(sel), 8'h07);
        step();
        chk("reen_row1", 8'(sel), 8'h06);
        run(PERIOD);

        // Write and commit together, then a commit that must be ignored
        commit = 1'b1; wr_valid = 1'b1; wr_row = 3'd5; wr_data = 5'b10001;
        step();
        commit = 1'b0; wr_valid = 1'b0;
        write_row(3'd6, 5'b00011);
        pulse_commit();
        wait_tick("tick_collision");
        chk("single_swap_pend", 8'(commit_pend), 8'd0);
        run(PERIOD + 2);

        // Asynchronous reset in mid-scan
        run(12);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
        run(3);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            en = ($urandom_range(0, 99) != 0);
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_row = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 4);
                b = (a + $urandom_range(1, 4)) % 5;
                d = '0; d[a] = 1'b1; d[b] = 1'b1;
                wr_data = d;
            end else begin
                wr_data = 5'($urandom);
            end
            commit = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matriz_varredura.md
Name: matriz_varredura

Overview:
- Row-scan controller for the 7x5 LED matrix. It owns a double-buffered 7-row by 5-column frame store.
- It drives the 3-bit row-select code into the existing row decoder (A=sel[2], B=sel[1], C=sel[0]) and drives the 5 column lines.
- It sequences rows with a blanking gap between them, accepts row writes over a valid/ready handshake, and flags rows that are not valid 2-of-5 code words.

Parameters:
- DWELL_CYCLES, 1000: clock cycles each row is driven (>=1).
- BLANK_CYCLES, 8: clock cycles of blanking before each row (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  scan enable; low forces blanking.
- wr_valid  input  1  row write request.
- wr_ready  output  1  controller can accept a row write.
- wr_row  input  3  target row 1..7 (Lk); value 0 is illegal.
- wr_data  input  5  column pattern for the row; bit4 = leftmost column.
- commit  input  1  single-cycle pulse: publish back buffer at next frame boundary.
- sel  output  3  row-select code to the decoder; 3'b111 = no row lit.
- col  output  5  column drive for the selected row.
- frame_tick  output  1  one-cycle pulse at each frame boundary.
- commit_pend  output  1  commit requested, swap not yet done.
- code_err  output  1  sticky: a written row did not have exactly two ones.

Behaviour:
- Reset values: sel=3'b111, col=0, frame_tick=0, wr_ready=1, commit_pend=0, code_err=0. Front and back buffers all zero. State IDLE, row counter=1, timer=0.
- Row-to-code mapping is sel = 7 - k for row Lk: L1=110, L2=101, L3=100, L4=011, L5=010, L6=001, L7=000. Code 111 is the blank code.
- FSM states and transitions:
  - IDLE: sel=111, col=0. If en=1, go to BLANK with row=1.
  - BLANK: sel=111, col=0 for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: sel=7-row, col=front[row] for DWELL_CYCLES cycles.
    - At the end of a row with row<7: row+1, go to BLANK.
    - At the end of row 7: row=1, go to BLANK, and mark a frame boundary.
- Outputs are registered. sel and col change on the same edge as the state change, so there is no glitch between rows.
- Frame boundary:
  - frame_tick=1 for exactly the first BLANK cycle of row 1.
  - If commit_pend=1, front <= back (copy; back keeps its contents) on that same edge, and commit_pend clears.
- en=0 in any state: next edge goes to IDLE, sel=111, col=0, row=1. No frame_tick. A pending commit swaps on the next cycle while in IDLE.
- Write handshake:
  - A write transfers when wr_valid && wr_ready: back[wr_row] <= wr_data.
  - wr_ready = !commit_pend, so the back buffer is frozen until the swap.
  - wr_row=0 transfers (handshake completes), the data is discarded, and code_err is set.
- 2-of-5 check: on any transfer with popcount(wr_data) != 2, code_err is set. The data is still stored.
- code_err stays set until a commit pulse is accepted; it clears on that edge.
- commit handling:
  - commit is accepted when commit_pend=0; accepted commit sets commit_pend.
  - commit while commit_pend=1 is ignored.
  - Write transfer and commit in the same cycle: the write lands in back first, then pend is set. The write is included in the swap.
- Frame period = 7*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Asynchronous reset mid-scan returns all outputs to their reset values immediately. Buffers are cleared.

Decomposition:
- Package matriz_pkg holds:
  - constants N_ROWS=7, N_COLS=5, SEL_OFF=3'b111;
  - state enum {IDLE, BLANK, DRIVE};
  - function row_to_sel(k) = 7-k.
- Sub-module checa_dois_de_cinco: combinational popcount==2 check on 5 bits, output ok. It is reusable by the 2-of-5 encoder/decoder blocks.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=1 unless stated):
- Reset then en=1, front all zero -> sel sequence is 111 x1, 110 x4, 111 x1, 101 x4 ... 000 x4, with col=0 throughout. frame_tick pulses every 35 cycles.
- Write rows 1..7 with 5'b11000, 5'b10100, 5'b10010, 5'b10001, 5'b01100, 5'b01010, 5'b00110, then commit -> commit_pend=1 and wr_ready=0 until frame_tick. The following frame shows col=11000 while sel=110, through col=00110 while sel=000. code_err stays 0.
- Write row 3 with 5'b11100 -> code_err=1, data still displayed after commit. A subsequent commit clears code_err.
- Write with wr_row=0, data 5'b00011 -> handshake completes, no buffer changes, code_err=1.
- en dropped mid-DRIVE of row 4 (sel=011) -> next cycle sel=111, col=0. Re-enable -> one BLANK cycle, then sel=110 (row 1).
- commit and write in the same cycle, plus a second commit while pending -> the write appears in the next frame; the second commit has no effect; exactly one swap occurs.
